// File: rtl/jtdd_prog_sdram.sv
// Download-side SDRAM writer: buffers programming bytes in a small FIFO,
// merges byte pairs aimed at the same 16-bit word, and issues them to the
// SDRAM controller over a req/ack handshake.
//
//  state   | meaning
//  --------+-----------------------------------------------
//  ST_IDLE | no request outstanding; load head when FIFO non-empty
//  ST_REQ  | request presented, waiting for sdram_ack
module jtdd_prog_sdram #(
    parameter int AW    = 22,
    parameter int DEPTH = 4
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          downloading,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic [1:0]    prog_mask,
    input  logic          prog_we,
    output logic          sdram_req,
    output logic [AW-1:0] sdram_addr,
    output logic [15:0]   sdram_din,
    output logic [1:0]    sdram_dqm,
    input  logic          sdram_ack,
    output logic          prog_full,
    output logic          overflow,
    output logic          dwnld_done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    state_t state, state_nxt;

    logic [AW-1:0] fifo_addr [DEPTH];
    logic [15:0]   fifo_data [DEPTH];
    logic [1:0]    fifo_mask [DEPTH];

    logic [PW-1:0] rd_ptr, wr_ptr, tail_ptr;
    logic [CW-1:0] count;
    logic          empty, lane_valid, merge, push, drop, pop, load;
    logic          dl_q, dl_rise, dl_fall, pending, done_cond;

    assign tail_ptr   = wr_ptr - PW'(1);
    assign empty      = (count == '0);
    assign prog_full  = (count == CW'(DEPTH));
    assign lane_valid = prog_we && (prog_mask != 2'b11);

    // The tail may only absorb a byte if it is not the entry being presented
    // and the two writes touch disjoint lanes of the same word.
    assign merge = lane_valid && !empty && (tail_ptr != rd_ptr) &&
                   (fifo_addr[tail_ptr] == prog_addr) &&
                   ((fifo_mask[tail_ptr] | prog_mask) == 2'b11);

    // A pop in the same cycle frees a slot, so a push at full still fits.
    assign push = lane_valid && !merge && (!prog_full || pop);
    assign drop = lane_valid && !merge && prog_full && !pop;

    assign dl_rise   = downloading && !dl_q;
    assign dl_fall   = !downloading && dl_q;
    assign done_cond = pending && empty && (state == ST_IDLE) && !prog_we && !dl_rise;

    // FIFO storage: write new entries at wr_ptr or patch a lane of the tail
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= prog_addr;
            fifo_data[wr_ptr] <= {prog_data, prog_data};
            fifo_mask[wr_ptr] <= prog_mask;
        end else if (merge) begin
            if (!prog_mask[0]) fifo_data[tail_ptr][7:0]  <= prog_data;
            if (!prog_mask[1]) fifo_data[tail_ptr][15:8] <= prog_data;
            fifo_mask[tail_ptr] <= fifo_mask[tail_ptr] & prog_mask;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (!empty)   state_nxt = ST_REQ;
            ST_REQ:  if (sdram_ack) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: request flag, head load and pop strobes
    always_comb begin
        sdram_req = 1'b0;
        load      = 1'b0;
        pop       = 1'b0;
        case (state)
            ST_IDLE: load = !empty;
            ST_REQ: begin
                sdram_req = 1'b1;
                pop       = sdram_ack;
            end
            default: ;
        endcase
    end

    // Request payload registers, captured from the head when leaving IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdram_addr <= '0;
            sdram_din  <= '0;
            sdram_dqm  <= 2'b11;
        end else if (load) begin
            sdram_addr <= fifo_addr[rd_ptr];
            sdram_din  <= fifo_data[rd_ptr];
            sdram_dqm  <= fifo_mask[rd_ptr];
        end
    end

    // Overflow flag and end-of-download completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_q       <= 1'b0;
            pending    <= 1'b0;
            dwnld_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            dl_q       <= downloading;
            dwnld_done <= done_cond;
            if (dl_rise)        pending <= 1'b0;
            else if (dl_fall)   pending <= 1'b1;
            else if (done_cond) pending <= 1'b0;
            if (dl_rise)        overflow <= 1'b0;
            else if (drop)      overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jtdd_prog_sdram.sv
// Directed bench for jtdd_prog_sdram: merge, latency, full/overflow,
// push-at-full with pop, completion pulse and async reset.
module tb_jtdd_prog_sdram;

    logic        rst, clk, downloading;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic [15:0] sdram_din;
    logic [1:0]  sdram_dqm;
    logic        sdram_ack;
    logic        prog_full, overflow, dwnld_done;

    int vectors = 0;
    int errors  = 0;
    int done_cnt = 0;

    jtdd_prog_sdram #(.AW(22), .DEPTH(4)) dut (
        .rst(rst), .clk(clk), .downloading(downloading),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_we(prog_we), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_din(sdram_din), .sdram_dqm(sdram_dqm), .sdram_ack(sdram_ack),
        .prog_full(prog_full), .overflow(overflow), .dwnld_done(dwnld_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (dwnld_done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one byte write; returns on the negedge after it was sampled
    task automatic push(input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
        prog_addr = a; prog_data = d; prog_mask = m; prog_we = 1'b1;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Wait for a request, check payload, ack after 'dly' cycles, check req drops
    task automatic service(input string tag, input logic [21:0] a, input logic [15:0] d,
                           input logic [1:0] m, input int dly);
        int n = 0;
        while (!sdram_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!sdram_req) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        repeat (dly) @(negedge clk);
        chk({tag, "_req"},  {31'd0, sdram_req}, 1);
        chk({tag, "_addr"}, {10'd0, sdram_addr}, {10'd0, a});
        chk({tag, "_din"},  {16'd0, sdram_din}, {16'd0, d});
        chk({tag, "_dqm"},  {30'd0, sdram_dqm}, {30'd0, m});
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        chk({tag, "_req_low"}, {31'd0, sdram_req}, 0);
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        int seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (sdram_req) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        rst = 1'b1; downloading = 1'b0; prog_addr = '0; prog_data = '0;
        prog_mask = 2'b11; prog_we = 1'b0; sdram_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req",  {31'd0, sdram_req}, 0);
        chk("rst_dqm",  {30'd0, sdram_dqm}, 2'b11);
        chk("rst_din",  {16'd0, sdram_din}, 0);
        chk("rst_full", {31'd0, prog_full}, 0);
        chk("rst_ovf",  {31'd0, overflow}, 0);
        chk("rst_done", {31'd0, dwnld_done}, 0);
        rst = 1'b0;
        @(negedge clk);
        downloading = 1'b1;
        @(negedge clk);

        // 1: filler occupies the presented slot, then two lanes merge behind it
        push(22'h3,   8'hFF, 2'b10);
        push(22'h100, 8'h12, 2'b10);
        push(22'h100, 8'h34, 2'b01);
        service("t1_fill", 22'h3,   16'hFFFF, 2'b10, 3);
        service("t1_word", 22'h100, 16'h3412, 2'b00, 3);
        expect_idle("t1_single", 6);

        // 2: single high byte, one-cycle latency to req
        push(22'h20000, 8'hAA, 2'b01);
        chk("t2_req_lat0", {31'd0, sdram_req}, 0);
        @(negedge clk);
        chk("t2_req_lat1", {31'd0, sdram_req}, 1);
        service("t2", 22'h20000, 16'hAAAA, 2'b01, 0);

        // 3: fill while stalled, fifth byte dropped
        for (int i = 0; i < 5; i++) begin
            push(22'h10 + 22'(i), 8'h60 + 8'(i), 2'b10);
            if (i == 2) chk("t3_notfull", {31'd0, prog_full}, 0);
            if (i == 3) chk("t3_full",    {31'd0, prog_full}, 1);
        end
        chk("t3_ovf", {31'd0, overflow}, 1);
        for (int i = 0; i < 4; i++)
            service("t3", 22'h10 + 22'(i), {2{8'h60 + 8'(i)}}, 2'b10, 1);
        expect_idle("t3_no5th", 6);
        chk("t3_ovf_sticky", {31'd0, overflow}, 1);

        // downloading pulse low for one cycle: clears overflow, no done pulse
        downloading = 1'b0;
        @(negedge clk);
        downloading = 1'b1;
        repeat (3) @(negedge clk);
        chk("ovf_clear", {31'd0, overflow}, 0);
        chk("no_done_reassert", done_cnt, 0);

        // 4: push at full together with ack
        for (int i = 0; i < 4; i++) push(22'h40 + 22'(i), 8'h70 + 8'(i), 2'b01);
        chk("t4_full", {31'd0, prog_full}, 1);
        chk("t4_req",  {31'd0, sdram_req}, 1);
        chk("t4_head", {10'd0, sdram_addr}, 32'h40);
        sdram_ack = 1'b1;
        prog_addr = 22'h44; prog_data = 8'h74; prog_mask = 2'b01; prog_we = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0; prog_we = 1'b0;
        chk("t4_ovf",   {31'd0, overflow}, 0);
        chk("t4_full2", {31'd0, prog_full}, 1);
        for (int i = 1; i < 5; i++)
            service("t4", 22'h40 + 22'(i), {2{8'h70 + 8'(i)}}, 2'b01, 0);
        expect_idle("t4_drain", 4);

        // 5: downloading falls with two entries outstanding
        push(22'h50, 8'h81, 2'b10);
        push(22'h51, 8'h82, 2'b10);
        downloading = 1'b0;
        service("t5a", 22'h50, 16'h8181, 2'b10, 2);
        chk("t5_no_early", done_cnt, 0);
        service("t5b", 22'h51, 16'h8282, 2'b10, 2);
        chk("t5_done0", {31'd0, dwnld_done}, 0);
        @(negedge clk);
        chk("t5_done1", {31'd0, dwnld_done}, 1);
        @(negedge clk);
        chk("t5_done2", {31'd0, dwnld_done}, 0);
        repeat (4) @(negedge clk);
        chk("t5_once", done_cnt, 1);

        // 6: async reset mid-request
        downloading = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) push(22'h80 + 22'(i), 8'h90, 2'b10);
        chk("t6_pre_req", {31'd0, sdram_req}, 1);
        chk("t6_pre_ovf", {31'd0, overflow}, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_req",  {31'd0, sdram_req}, 0);
        chk("t6_dqm",  {30'd0, sdram_dqm}, 2'b11);
        chk("t6_ovf",  {31'd0, overflow}, 0);
        chk("t6_full", {31'd0, prog_full}, 0);
        @(negedge clk);
        rst = 1'b0;
        expect_idle("t6_flushed", 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
